// File: rtl/affine_pkg.sv
// Shared widths and constants for the affine interpolation filter accumulator.
package affine_pkg;
  localparam int SAMPLE_W  = 11;
  localparam int PROD_W    = 15;
  localparam int ACC_W     = 18;
  localparam int NTAPS     = 6;
  localparam int ROUND_OFS = 32;
  localparam int SHIFT     = 6;
  localparam int SUBBLK_N  = 16;

  localparam int PAIR_W = PROD_W + 1;
  localparam int NPAIRS = NTAPS / 2;
  localparam int CNT_W  = $clog2(SUBBLK_N);

  typedef logic signed [PROD_W-1:0]   prod_t;
  typedef logic signed [PAIR_W-1:0]   pair_t;
  typedef logic signed [ACC_W-1:0]    acc_t;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/affine_round_clip_11.sv
// Final scaling: floor shift of the rounded accumulator, saturate to the sample range,
// or pass the integer-position sample straight through when the phase is zero.
module affine_round_clip_11
  import affine_pkg::*;
(
  input  acc_t    total,
  input  logic    bypass,
  input  sample_t center,
  output sample_t y
);

  localparam acc_t YMAX = acc_t'((1 <<< (SAMPLE_W - 1)) - 1);
  localparam acc_t YMIN = acc_t'(-(1 <<< (SAMPLE_W - 1)));

  acc_t shifted;

  always_comb begin
    shifted = total >>> SHIFT;
    if (bypass)
      y = center;
    else if (shifted > YMAX)
      y = YMAX[SAMPLE_W-1:0];
    else if (shifted < YMIN)
      y = YMIN[SAMPLE_W-1:0];
    else
      y = shifted[SAMPLE_W-1:0];
  end

endmodule

// File: rtl/affine_filter_accum_11.sv
// Three-stage accumulator for six pre-multiplied taps: pair sums, rounded total,
// then shift/clip; one global advance enable stalls the whole pipe on backpressure.
module affine_filter_accum_11
  import affine_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  prod_t         p0,
  input  prod_t         p1,
  input  prod_t         p2,
  input  prod_t         p3,
  input  prod_t         p4,
  input  prod_t         p5,
  input  sample_t       center_in,
  input  logic [3:0]    frac_in,
  input  logic          valid_in,
  output logic          ready_in,
  output sample_t       y_out,
  output logic          valid_out,
  input  logic          ready_out,
  output logic          last_out,
  input  logic          flush
);

  logic             adv;
  logic             accept;
  prod_t            prod   [NTAPS];
  pair_t            pair_d [NPAIRS];
  acc_t             total_d;
  sample_t          y_d;

  logic             s1_valid;
  pair_t            s1_pair [NPAIRS];
  logic             s1_byp;
  sample_t          s1_center;

  logic             s2_valid;
  acc_t             s2_total;
  logic             s2_byp;
  sample_t          s2_center;

  logic [CNT_W-1:0] cnt;

  assign prod[0] = p0;
  assign prod[1] = p1;
  assign prod[2] = p2;
  assign prod[3] = p3;
  assign prod[4] = p4;
  assign prod[5] = p5;

  assign adv      = !valid_out || ready_out;
  assign ready_in = adv;
  assign accept   = valid_in && adv;
  assign last_out = valid_out && (cnt == CNT_W'(SUBBLK_N - 1));

  always_comb begin
    for (int i = 0; i < NPAIRS; i++)
      pair_d[i] = PAIR_W'(prod[2*i]) + PAIR_W'(prod[2*i+1]);
  end

  always_comb begin
    total_d = acc_t'(ROUND_OFS);
    for (int i = 0; i < NPAIRS; i++)
      total_d = total_d + ACC_W'(s1_pair[i]);
  end

  affine_round_clip_11 u_round_clip (
    .total  (s2_total),
    .bypass (s2_byp),
    .center (s2_center),
    .y      (y_d)
  );

  // Stage valids and the sub-block counter; flush wins over any acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      valid_out <= 1'b0;
      cnt       <= '0;
    end else begin
      if (flush) begin
        s1_valid  <= 1'b0;
        s2_valid  <= 1'b0;
        valid_out <= 1'b0;
      end else if (adv) begin
        s1_valid  <= accept;
        s2_valid  <= s1_valid;
        valid_out <= s2_valid;
      end
      if (flush)
        cnt <= '0;
      else if (valid_out && ready_out)
        cnt <= cnt + 1'b1;
    end
  end

  // Data only moves on a real sample so idle-bus garbage never enters the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPAIRS; i++)
        s1_pair[i] <= '0;
      s1_byp    <= 1'b0;
      s1_center <= '0;
      s2_total  <= '0;
      s2_byp    <= 1'b0;
      s2_center <= '0;
      y_out     <= '0;
    end else if (adv) begin
      if (accept) begin
        for (int i = 0; i < NPAIRS; i++)
          s1_pair[i] <= pair_d[i];
        s1_byp    <= (frac_in == 4'd0);
        s1_center <= center_in;
      end
      if (s1_valid) begin
        s2_total  <= total_d;
        s2_byp    <= s1_byp;
        s2_center <= s1_center;
      end
      if (s2_valid)
        y_out <= y_d;
    end
  end

endmodule

// File: tb/tb_affine_filter_accum_11.sv
// Self-checking bench: directed corner vectors plus randomized streams against a
// plain-arithmetic reference of the filter output and sub-block counting.
module tb_affine_filter_accum_11;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               valid_in;
  logic               ready_out;
  logic signed [14:0] p [6];
  logic signed [10:0] center_in;
  logic [3:0]         frac_in;
  logic               ready_in;
  logic               valid_out;
  logic               last_out;
  logic signed [10:0] y_out;

  int tests = 0;
  int fails = 0;
  int expq[$];
  int mc;

  affine_filter_accum_11 dut (
    .clk       (clk),
    .rst       (rst),
    .p0        (p[0]),
    .p1        (p[1]),
    .p2        (p[2]),
    .p3        (p[3]),
    .p4        (p[4]),
    .p5        (p[5]),
    .center_in (center_in),
    .frac_in   (frac_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .y_out     (y_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .last_out  (last_out),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: sum of products + 32, floor-divide by 64, saturate; phase 0 passes center.
  function automatic int ref_y();
    int t, q;
    if (frac_in == 4'd0) return int'(center_in);
    t = 32;
    for (int i = 0; i < 6; i++) t += int'(p[i]);
    q = (t >= 0) ? t / 64 : -((-t + 63) / 64);
    if (q > 1023) q = 1023;
    if (q < -1024) q = -1024;
    return q;
  endfunction

  task automatic rand_inputs(input bit v);
    for (int i = 0; i < 6; i++) p[i] = 15'($urandom_range(0, 32767));
    center_in = 11'($urandom_range(0, 2047));
    frac_in   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    valid_in  = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    ready_out = 1'b1;
    rand_inputs(1'b0);
    tick();
    tick();
    rst = 1'b0;
    mc = 0;
    expq.delete();
  endtask

  // Push n samples through with ready_out high, checking data order and last_out.
  task automatic burst(input int n);
    int sent = 0;
    int got = 0;
    int e;
    for (int cyc = 0; cyc < n + 20 && got < n; cyc++) begin
      rand_inputs(sent < n);
      ready_out = 1'b1;
      #1;
      if (valid_in && ready_in) begin
        expq.push_back(ref_y());
        sent++;
      end
      if (valid_out && ready_out) begin
        tests++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL burst_spurious: got y=%0d with no sample pending", y_out);
        end else begin
          e = expq.pop_front();
          if (int'(y_out) != e) begin
            fails++;
            $display("FAIL burst_y: got %0d expected %0d (transfer %0d)", y_out, e, got);
          end
        end
        tests++;
        if (last_out !== ((mc % 16) == 15)) begin
          fails++;
          $display("FAIL burst_last: got %0b expected %0b (count %0d)", last_out, ((mc % 16) == 15), mc);
        end
        mc++;
        got++;
      end
      tick();
    end
    rand_inputs(1'b0);
    tests++;
    if (got != n) begin
      fails++;
      $display("FAIL burst_timeout: got %0d transfers expected %0d", got, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    ready_out = 1'b0;
    rand_inputs(1'b0);
    #1;
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", valid_out); end
    tests++; if (last_out !== 1'b0) begin fails++; $display("FAIL reset_last: got %0b expected 0", last_out); end
    tests++; if (y_out !== 11'sd0) begin fails++; $display("FAIL reset_y: got %0d expected 0", y_out); end
    tests++; if (ready_in !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b expected 1", ready_in); end
    tick();
    tick();
    rst = 1'b0;
    ready_out = 1'b1;
  endtask

  task automatic test_directed();
    int e;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      rand_inputs(1'b1);
      ready_out = 1'b1;
      case (k)
        0: begin for (int i = 0; i < 6; i++) p[i] = 15'sd0; p[2] = 15'sd6400;  frac_in = 4'd5; e = 100;   end
        1: begin for (int i = 0; i < 6; i++) p[i] = 15'sd0; p[2] = -15'sd6400; frac_in = 4'd5; e = -100;  end
        2: begin for (int i = 0; i < 6; i++) p[i] = 15'sd16383;  frac_in = 4'd3; e = 1023;  end
        3: begin for (int i = 0; i < 6; i++) p[i] = -15'sd16384; frac_in = 4'd9; e = -1024; end
        default: begin center_in = -11'sd7; frac_in = 4'd0; e = -7; end
      endcase
      #1;
      tests++; if (ready_in !== 1'b1) begin fails++; $display("FAIL dir_ready[%0d]: got %0b expected 1", k, ready_in); end
      tick();
      rand_inputs(1'b0);
      tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL dir_lat1[%0d]: valid_out %0b expected 0", k, valid_out); end
      tick();
      tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL dir_lat2[%0d]: valid_out %0b expected 0", k, valid_out); end
      tick();
      tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL dir_lat3[%0d]: valid_out %0b expected 1", k, valid_out); end
      tests++; if (int'(y_out) != e) begin fails++; $display("FAIL dir_y[%0d]: got %0d expected %0d", k, y_out, e); end
      tick();
    end
  endtask

  task automatic test_stream_stall();
    bit hold = 1'b0;
    logic signed [10:0] held = '0;
    int e;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc >= 200 && expq.size() == 0 && !valid_out) break;
      rand_inputs(cyc < 200 && $urandom_range(0, 3) != 0);
      if (cyc >= 40 && cyc < 45) ready_out = 1'b0;
      else if (cyc >= 200) ready_out = 1'b1;
      else ready_out = ($urandom_range(0, 3) != 0);
      #1;
      if (hold) begin
        tests++;
        if (!(valid_out && y_out == held)) begin
          fails++;
          $display("FAIL stall_hold: valid=%0b y=%0d expected held y=%0d", valid_out, y_out, held);
        end
      end
      if (cyc >= 42 && cyc < 45 && valid_out) begin
        tests++;
        if (ready_in !== 1'b0) begin fails++; $display("FAIL stall_ready: got %0b expected 0", ready_in); end
      end
      if (valid_in && ready_in) expq.push_back(ref_y());
      if (valid_out && ready_out) begin
        tests++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL stream_spurious: got y=%0d with no sample pending", y_out);
        end else begin
          e = expq.pop_front();
          if (int'(y_out) != e) begin fails++; $display("FAIL stream_y: got %0d expected %0d", y_out, e); end
        end
        tests++;
        if (last_out !== ((mc % 16) == 15)) begin
          fails++;
          $display("FAIL stream_last: got %0b expected %0b (count %0d)", last_out, ((mc % 16) == 15), mc);
        end
        mc++;
      end
      hold = valid_out && !ready_out;
      held = y_out;
      tick();
    end
    rand_inputs(1'b0);
    tests++;
    if (expq.size() != 0) begin fails++; $display("FAIL stream_lost: %0d samples never emerged", expq.size()); end
  endtask

  task automatic test_last_flush();
    do_reset();
    burst(32);
    burst(7);
    rand_inputs(1'b1);
    flush = 1'b1;
    #1;
    tick();
    flush = 1'b0;
    rand_inputs(1'b0);
    mc = 0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (valid_out !== 1'b0) begin fails++; $display("FAIL flush_drop: valid_out %0b expected 0 at idle %0d", valid_out, i); end
      tick();
    end
    burst(16);
  endtask

  task automatic test_reset_midstream();
    do_reset();
    burst(5);
    ready_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs(1'b1);
      tick();
    end
    rand_inputs(1'b0);
    rst = 1'b1;
    #1;
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %0b expected 0", valid_out); end
    tests++; if (last_out !== 1'b0) begin fails++; $display("FAIL mid_rst_last: got %0b expected 0", last_out); end
    tests++; if (y_out !== 11'sd0) begin fails++; $display("FAIL mid_rst_y: got %0d expected 0", y_out); end
    tick();
    rst = 1'b0;
    mc = 0;
    expq.delete();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (valid_out !== 1'b0) begin fails++; $display("FAIL mid_rst_stale: valid_out %0b expected 0 at idle %0d", valid_out, i); end
      tick();
    end
    burst(16);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream_stall();
    test_last_flush();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
